// File: rtl/wb_stage_q.sv
// Writeback stage: commits RF/CSR writes, raises exception/ertn flush, and
// queues retired instructions into a trace FIFO that back-pressures the pipe.
module wb_stage_q #(
  parameter int DATA_W      = 32,
  parameter int RF_AW       = 5,
  parameter int TRACE_DEPTH = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                mem_valid,
  output logic                wb_allowin,
  input  logic [31:0]         mem_pc,
  input  logic                mem_gr_we,
  input  logic [RF_AW-1:0]    mem_dest,
  input  logic [DATA_W-1:0]   mem_result,
  input  logic                mem_csr_re,
  input  logic                mem_csr_we,
  input  logic [13:0]         mem_csr_num,
  input  logic [DATA_W-1:0]   mem_csr_wmask,
  input  logic [DATA_W-1:0]   mem_csr_wvalue,
  input  logic                mem_ex,
  input  logic [5:0]          mem_ecode,
  input  logic [8:0]          mem_esubcode,
  input  logic                mem_ertn,
  output logic                csr_re,
  output logic                csr_we,
  output logic [13:0]         csr_num,
  input  logic [DATA_W-1:0]   csr_rvalue,
  output logic [DATA_W-1:0]   csr_wmask,
  output logic [DATA_W-1:0]   csr_wvalue,
  output logic                wb_ex,
  output logic                ertn_flush,
  output logic [31:0]         wb_pc,
  output logic [5:0]          wb_ecode,
  output logic [8:0]          wb_esubcode,
  output logic                rf_we,
  output logic [RF_AW-1:0]    rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                wb_valid,
  output logic                wb_gr_we,
  output logic [RF_AW-1:0]    wb_dest,
  output logic                trace_valid,
  input  logic                trace_ready,
  output logic [31:0]         trace_pc,
  output logic [DATA_W/8-1:0] trace_we,
  output logic [RF_AW-1:0]    trace_waddr,
  output logic [DATA_W-1:0]   trace_wdata
);
  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WE_W  = DATA_W / 8;

  typedef struct packed {
    logic [31:0]       pc;
    logic              gr_we;
    logic [RF_AW-1:0]  dest;
    logic [DATA_W-1:0] result;
    logic              csr_re;
    logic              csr_we;
    logic [13:0]       csr_num;
    logic [DATA_W-1:0] csr_wmask;
    logic [DATA_W-1:0] csr_wvalue;
    logic              ex;
    logic [5:0]        ecode;
    logic [8:0]        esubcode;
    logic              ertn;
  } wb_req_t;

  typedef struct packed {
    logic [31:0]       pc;
    logic [WE_W-1:0]   we;
    logic [RF_AW-1:0]  waddr;
    logic [DATA_W-1:0] wdata;
  } trace_ent_t;

  wb_req_t    mem_req, wb_q;
  trace_ent_t push_ent;
  trace_ent_t fifo [TRACE_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic trace_full, ready_go, retire, flush, load, push, pop;

  always_comb begin
    mem_req            = '0;
    mem_req.pc         = mem_pc;
    mem_req.gr_we      = mem_gr_we;
    mem_req.dest       = mem_dest;
    mem_req.result     = mem_result;
    mem_req.csr_re     = mem_csr_re;
    mem_req.csr_we     = mem_csr_we;
    mem_req.csr_num    = mem_csr_num;
    mem_req.csr_wmask  = mem_csr_wmask;
    mem_req.csr_wvalue = mem_csr_wvalue;
    mem_req.ex         = mem_ex;
    mem_req.ecode      = mem_ecode;
    mem_req.esubcode   = mem_esubcode;
    mem_req.ertn       = mem_ertn;
  end

  // Exceptions never take a trace slot, so they retire even when the FIFO is full.
  assign trace_full = (count == CNT_W'(TRACE_DEPTH));
  assign ready_go   = wb_q.ex | ~trace_full;
  assign wb_allowin = ~wb_valid | ready_go;
  assign retire     = wb_valid & ready_go;
  assign flush      = wb_ex | ertn_flush;
  assign load       = mem_valid & wb_allowin & ~flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     wb_valid <= 1'b0;
    else if (flush)  wb_valid <= 1'b0;
    else if (load)   wb_valid <= 1'b1;
    else if (retire) wb_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (load) wb_q <= mem_req;
  end

  assign rf_we       = retire & wb_q.gr_we & ~wb_q.ex;
  assign rf_waddr    = wb_q.dest;
  assign rf_wdata    = wb_q.csr_re ? csr_rvalue : wb_q.result;
  assign csr_re      = wb_valid & wb_q.csr_re;
  assign csr_we      = retire & wb_q.csr_we & ~wb_q.ex;
  assign csr_num     = wb_q.csr_num;
  assign csr_wmask   = wb_q.csr_wmask;
  assign csr_wvalue  = wb_q.csr_wvalue;
  assign wb_ex       = retire & wb_q.ex;
  assign ertn_flush  = retire & wb_q.ertn & ~wb_q.ex;
  assign wb_pc       = wb_q.pc;
  assign wb_ecode    = wb_q.ecode;
  assign wb_esubcode = wb_q.esubcode;
  assign wb_gr_we    = wb_valid & wb_q.gr_we & ~wb_q.ex;
  assign wb_dest     = wb_q.dest;

  assign push = retire & ~wb_q.ex;
  assign pop  = trace_valid & trace_ready;

  always_comb begin
    push_ent       = '0;
    push_ent.pc    = wb_q.pc;
    push_ent.we    = {WE_W{rf_we}};
    push_ent.waddr = wb_q.dest;
    push_ent.wdata = rf_wdata;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= push_ent;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign trace_valid = (count != '0);
  assign trace_pc    = fifo[rd_ptr].pc;
  assign trace_we    = fifo[rd_ptr].we;
  assign trace_waddr = fifo[rd_ptr].waddr;
  assign trace_wdata = fifo[rd_ptr].wdata;
endmodule

// File: tb/tb_wb_stage_q.sv
// Directed cycle-by-cycle vectors for wb_stage_q plus a mid-operation reset sequence.
module tb_wb_stage_q;
  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid, wb_allowin;
  logic [31:0] mem_pc;
  logic        mem_gr_we;
  logic [4:0]  mem_dest;
  logic [31:0] mem_result;
  logic        mem_csr_re, mem_csr_we;
  logic [13:0] mem_csr_num;
  logic [31:0] mem_csr_wmask, mem_csr_wvalue;
  logic        mem_ex;
  logic [5:0]  mem_ecode;
  logic [8:0]  mem_esubcode;
  logic        mem_ertn;
  logic        csr_re, csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue, csr_wmask, csr_wvalue;
  logic        wb_ex, ertn_flush;
  logic [31:0] wb_pc;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_valid, wb_gr_we;
  logic [4:0]  wb_dest;
  logic        trace_valid, trace_ready;
  logic [31:0] trace_pc;
  logic [3:0]  trace_we;
  logic [4:0]  trace_waddr;
  logic [31:0] trace_wdata;

  wb_stage_q #(.DATA_W(32), .RF_AW(5), .TRACE_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .wb_allowin(wb_allowin),
    .mem_pc(mem_pc), .mem_gr_we(mem_gr_we), .mem_dest(mem_dest), .mem_result(mem_result),
    .mem_csr_re(mem_csr_re), .mem_csr_we(mem_csr_we), .mem_csr_num(mem_csr_num),
    .mem_csr_wmask(mem_csr_wmask), .mem_csr_wvalue(mem_csr_wvalue),
    .mem_ex(mem_ex), .mem_ecode(mem_ecode), .mem_esubcode(mem_esubcode), .mem_ertn(mem_ertn),
    .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_pc(wb_pc), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_valid(wb_valid), .wb_gr_we(wb_gr_we), .wb_dest(wb_dest),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
    .trace_we(trace_we), .trace_waddr(trace_waddr), .trace_wdata(trace_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic        ex;
    logic [5:0]  ecode;
    logic        ertn;
  } ins_t;

  // flg = {csr_re, csr_we, wb_ex, ertn_flush}
  typedef struct packed {
    logic        mv;
    ins_t        in;
    logic        tr;
    logic [31:0] rv;
    logic        al, wv, rfwe;
    logic [4:0]  rfa;
    logic [31:0] rfd;
    logic [3:0]  flg;
    logic [13:0] cn;
    logic [5:0]  ec;
    logic        tv;
    logic [31:0] tpc;
    logic [3:0]  twe;
    logic [31:0] twd;
  } row_t;

  localparam logic [31:0] WMASK = 32'hffff00ff;
  localparam logic [31:0] WVAL  = 32'h12345678;

  row_t rows[$];
  int   asserts = 0;
  int   fails   = 0;

  function automatic ins_t alu(input logic [31:0] pc, input logic [4:0] d, input logic [31:0] r);
    ins_t x;
    x = '0;
    x.pc = pc; x.gr_we = 1'b1; x.dest = d; x.result = r;
    return x;
  endfunction

  task automatic add(input logic mv, input ins_t in, input logic tr, input logic [31:0] rv,
                     input logic al, input logic wv, input logic rfwe, input logic [4:0] rfa,
                     input logic [31:0] rfd, input logic [3:0] flg, input logic [13:0] cn,
                     input logic [5:0] ec, input logic tv, input logic [31:0] tpc,
                     input logic [3:0] twe, input logic [31:0] twd);
    row_t r;
    r.mv = mv; r.in = in; r.tr = tr; r.rv = rv; r.al = al; r.wv = wv; r.rfwe = rfwe;
    r.rfa = rfa; r.rfd = rfd; r.flg = flg; r.cn = cn; r.ec = ec; r.tv = tv;
    r.tpc = tpc; r.twe = twe; r.twd = twd;
    rows.push_back(r);
  endtask

  task automatic drive(input logic mv, input ins_t in, input logic tr, input logic [31:0] rv);
    mem_valid   = mv;
    mem_pc      = in.pc;      mem_gr_we   = in.gr_we;   mem_dest    = in.dest;
    mem_result  = in.result;  mem_csr_re  = in.csr_re;  mem_csr_we  = in.csr_we;
    mem_csr_num = in.csr_num; mem_ex      = in.ex;      mem_ecode   = in.ecode;
    mem_ertn    = in.ertn;    trace_ready = tr;         csr_rvalue  = rv;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL row %0d %s: got %h, expected %h", idx, name, act, exp);
    end
  endtask

  task automatic idle_chk(input int idx);
    chk("wb_valid", idx, 32'(wb_valid), 0);
    chk("trace_valid", idx, 32'(trace_valid), 0);
    chk("wb_allowin", idx, 32'(wb_allowin), 1);
    chk("rf_we", idx, 32'(rf_we), 0);
    chk("csr_we", idx, 32'(csr_we), 0);
    chk("csr_re", idx, 32'(csr_re), 0);
    chk("wb_ex", idx, 32'(wb_ex), 0);
    chk("ertn_flush", idx, 32'(ertn_flush), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t ni, k, w, s, n, e, p, q;
    ins_t ii[4];
    ins_t jj[5];
    ins_t mm[4];
    ni = '0;
    for (int i = 0; i < 4; i++) ii[i] = alu(32'h1c000000 + 32'(4*i), 5'(4+i), 32'h100 + 32'(i));
    for (int i = 0; i < 5; i++) jj[i] = alu(32'h1c000100 + 32'(4*i), 5'(8+i), 32'h200 + 32'(i));
    for (int i = 0; i < 4; i++) mm[i] = alu(32'h1c000300 + 32'(4*i), 5'(16+i), 32'h300 + 32'(i));
    k = alu(32'h1c000200, 5'd10, 32'h55); k.csr_re = 1'b1; k.csr_num = 14'h5;
    w = alu(32'h1c000204, 5'd11, 32'h66); w.csr_re = 1'b1; w.csr_we = 1'b1; w.csr_num = 14'h6;
    s = alu(32'h1c000310, 5'd20, 32'h77); s.ex = 1'b1; s.ecode = 6'hb; s.csr_we = 1'b1; s.csr_num = 14'h6;
    n = alu(32'h1c000400, 5'd21, 32'h400);
    e = alu(32'h1c000500, 5'd0, 32'h0); e.gr_we = 1'b0; e.ertn = 1'b1;
    p = alu(32'h1c000504, 5'd22, 32'h500);

    // Back-to-back ALU writes, trace drained every cycle
    add(1, ii[0], 1, 0, 1, 0, 0, 0, 0,        4'b0000, 0, 0, 0, 0, 0, 0);
    add(1, ii[1], 1, 0, 1, 1, 1, 4, 32'h100,  4'b0000, 0, 0, 0, 0, 0, 0);
    add(1, ii[2], 1, 0, 1, 1, 1, 5, 32'h101,  4'b0000, 0, 0, 1, 32'h1c000000, 4'hf, 32'h100);
    add(1, ii[3], 1, 0, 1, 1, 1, 6, 32'h102,  4'b0000, 0, 0, 1, 32'h1c000004, 4'hf, 32'h101);
    add(0, ni,    1, 0, 1, 1, 1, 7, 32'h103,  4'b0000, 0, 0, 1, 32'h1c000008, 4'hf, 32'h102);
    add(0, ni,    1, 0, 1, 0, 0, 0, 0,        4'b0000, 0, 0, 1, 32'h1c00000c, 4'hf, 32'h103);
    add(0, ni,    1, 0, 1, 0, 0, 0, 0,        4'b0000, 0, 0, 0, 0, 0, 0);
    // Trace stalled: four fill the FIFO, fifth held until a slot frees
    add(1, jj[0], 0, 0, 1, 0, 0, 0, 0,        4'b0000, 0, 0, 0, 0, 0, 0);
    add(1, jj[1], 0, 0, 1, 1, 1, 8, 32'h200,  4'b0000, 0, 0, 0, 0, 0, 0);
    add(1, jj[2], 0, 0, 1, 1, 1, 9, 32'h201,  4'b0000, 0, 0, 1, 32'h1c000100, 4'hf, 32'h200);
    add(1, jj[3], 0, 0, 1, 1, 1, 10, 32'h202, 4'b0000, 0, 0, 1, 32'h1c000100, 4'hf, 32'h200);
    add(1, jj[4], 0, 0, 1, 1, 1, 11, 32'h203, 4'b0000, 0, 0, 1, 32'h1c000100, 4'hf, 32'h200);
    add(0, ni,    0, 0, 0, 1, 0, 0, 0,        4'b0000, 0, 0, 1, 32'h1c000100, 4'hf, 32'h200);
    add(0, ni,    0, 0, 0, 1, 0, 0, 0,        4'b0000, 0, 0, 1, 32'h1c000100, 4'hf, 32'h200);
    add(0, ni,    1, 0, 0, 1, 0, 0, 0,        4'b0000, 0, 0, 1, 32'h1c000100, 4'hf, 32'h200);
    add(0, ni,    1, 0, 1, 1, 1, 12, 32'h204, 4'b0000, 0, 0, 1, 32'h1c000104, 4'hf, 32'h201);
    add(0, ni,    1, 0, 1, 0, 0, 0, 0,        4'b0000, 0, 0, 1, 32'h1c000108, 4'hf, 32'h202);
    add(0, ni,    1, 0, 1, 0, 0, 0, 0,        4'b0000, 0, 0, 1, 32'h1c00010c, 4'hf, 32'h203);
    add(0, ni,    1, 0, 1, 0, 0, 0, 0,        4'b0000, 0, 0, 1, 32'h1c000110, 4'hf, 32'h204);
    add(0, ni,    1, 0, 1, 0, 0, 0, 0,        4'b0000, 0, 0, 0, 0, 0, 0);
    // CSR read into rd, then csrwr (read + write)
    add(1, k,  1, 0,            1, 0, 0, 0, 0,             4'b0000, 0, 0, 0, 0, 0, 0);
    add(1, w,  1, 32'hdeadbeef, 1, 1, 1, 10, 32'hdeadbeef, 4'b1000, 14'h5, 0, 0, 0, 0, 0);
    add(0, ni, 1, 32'h0badf00d, 1, 1, 1, 11, 32'h0badf00d, 4'b1100, 14'h6, 0, 1, 32'h1c000200, 4'hf, 32'hdeadbeef);
    add(0, ni, 1, 0,            1, 0, 0, 0, 0,             4'b0000, 0, 0, 1, 32'h1c000204, 4'hf, 32'h0badf00d);
    add(0, ni, 1, 0,            1, 0, 0, 0, 0,             4'b0000, 0, 0, 0, 0, 0, 0);
    // Fill FIFO, then syscall retires past the full FIFO and flushes
    add(1, mm[0], 0, 0, 1, 0, 0, 0, 0,        4'b0000, 0, 0, 0, 0, 0, 0);
    add(1, mm[1], 0, 0, 1, 1, 1, 16, 32'h300, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(1, mm[2], 0, 0, 1, 1, 1, 17, 32'h301, 4'b0000, 0, 0, 1, 32'h1c000300, 4'hf, 32'h300);
    add(1, mm[3], 0, 0, 1, 1, 1, 18, 32'h302, 4'b0000, 0, 0, 1, 32'h1c000300, 4'hf, 32'h300);
    add(1, s,     0, 0, 1, 1, 1, 19, 32'h303, 4'b0000, 0, 0, 1, 32'h1c000300, 4'hf, 32'h300);
    add(1, n,     0, 0, 1, 1, 0, 0, 0,        4'b0010, 0, 6'hb, 1, 32'h1c000300, 4'hf, 32'h300);
    add(0, ni,    0, 0, 1, 0, 0, 0, 0,        4'b0000, 0, 0, 1, 32'h1c000300, 4'hf, 32'h300);
    add(0, ni,    1, 0, 1, 0, 0, 0, 0,        4'b0000, 0, 0, 1, 32'h1c000300, 4'hf, 32'h300);
    add(0, ni,    1, 0, 1, 0, 0, 0, 0,        4'b0000, 0, 0, 1, 32'h1c000304, 4'hf, 32'h301);
    add(0, ni,    1, 0, 1, 0, 0, 0, 0,        4'b0000, 0, 0, 1, 32'h1c000308, 4'hf, 32'h302);
    add(0, ni,    1, 0, 1, 0, 0, 0, 0,        4'b0000, 0, 0, 1, 32'h1c00030c, 4'hf, 32'h303);
    add(0, ni,    1, 0, 1, 0, 0, 0, 0,        4'b0000, 0, 0, 0, 0, 0, 0);
    // ertn: one-cycle flush, concurrent MEM instruction dropped, trace entry with we=0
    add(1, e,  1, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(1, p,  1, 0, 1, 1, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0);
    add(0, ni, 1, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 32'h1c000500, 4'h0, 32'h0);
    add(0, ni, 1, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);

    mem_csr_wmask = WMASK; mem_csr_wvalue = WVAL; mem_esubcode = 9'h0;
    drive(0, ni, 0, 0);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 idle_chk(-1);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < rows.size(); i++) begin
      row_t r;
      r = rows[i];
      drive(r.mv, r.in, r.tr, r.rv);
      @(negedge clk);
      chk("wb_allowin", i, 32'(wb_allowin), 32'(r.al));
      chk("wb_valid", i, 32'(wb_valid), 32'(r.wv));
      chk("rf_we", i, 32'(rf_we), 32'(r.rfwe));
      if (r.rfwe) begin
        chk("rf_waddr", i, 32'(rf_waddr), 32'(r.rfa));
        chk("rf_wdata", i, rf_wdata, r.rfd);
      end
      chk("csr_re", i, 32'(csr_re), 32'(r.flg[3]));
      chk("csr_we", i, 32'(csr_we), 32'(r.flg[2]));
      chk("wb_ex", i, 32'(wb_ex), 32'(r.flg[1]));
      chk("ertn_flush", i, 32'(ertn_flush), 32'(r.flg[0]));
      if (r.flg[3] | r.flg[2]) chk("csr_num", i, 32'(csr_num), 32'(r.cn));
      if (r.flg[2]) begin
        chk("csr_wmask", i, csr_wmask, WMASK);
        chk("csr_wvalue", i, csr_wvalue, WVAL);
      end
      if (r.flg[1]) chk("wb_ecode", i, 32'(wb_ecode), 32'(r.ec));
      chk("trace_valid", i, 32'(trace_valid), 32'(r.tv));
      if (r.tv) begin
        chk("trace_pc", i, trace_pc, r.tpc);
        chk("trace_we", i, 32'(trace_we), 32'(r.twe));
        chk("trace_wdata", i, trace_wdata, r.twd);
      end
      @(posedge clk); #1;
    end

    // Reset mid-operation: 3 trace entries queued and a valid instruction in WB
    for (int i = 0; i < 4; i++) begin
      q = alu(32'h1c000600 + 32'(4*i), 5'(24+i), 32'h600 + 32'(i));
      drive(1, q, 0, 0);
      @(posedge clk); #1;
    end
    drive(0, ni, 0, 0);
    chk("pre_reset wb_valid", 100, 32'(wb_valid), 1);
    chk("pre_reset trace_valid", 100, 32'(trace_valid), 1);
    chk("pre_reset rf_we", 100, 32'(rf_we), 1);
    chk("pre_reset trace_pc", 100, trace_pc, 32'h1c000600);
    resetn = 1'b0;
    #1 idle_chk(101);
    @(posedge clk); #1 idle_chk(102);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1 idle_chk(103);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
